// File: rtl/dpd_operand_unpack.sv
// Two-stage unpacker for a pair of DPD-encoded decimal32/decimal64 operands.
// Stage 1 decodes the combination field; stage 2 decodes the declets and classifies.
module dpd_operand_unpack #(
    parameter int FMT_W = 32,
    parameter int TAG_W = 4,
    localparam int EC   = (FMT_W == 32) ? 6 : 8,
    localparam int EW   = EC + 2,
    localparam int ND   = (FMT_W == 32) ? 7 : 16,
    localparam int NDEC = (ND - 1) / 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FMT_W-1:0] in_op1,
    input  logic [FMT_W-1:0] in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             s1,
    output logic             s2,
    output logic [EW-1:0]    e1,
    output logic [EW-1:0]    e2,
    output logic [4*ND-1:0]  m1,
    output logic [4*ND-1:0]  m2,
    output logic             inf1,
    output logic             nan1,
    output logic             snan1,
    output logic             zero1,
    output logic             inf2,
    output logic             nan2,
    output logic             snan2,
    output logic             zero2
);

    localparam int TW = 10 * NDEC;
    localparam int MW = 4 * ND;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [3:0]    msd;
        logic          inf;
        logic          nan;
        logic          snan;
        logic [TW-1:0] trail;
    } front_t;

    localparam int FRONT_W = $bits(front_t);

    // Infinity carries no coefficient, so its trailing field is cleared here and
    // decodes to zero downstream; a NaN keeps its trailing field as payload.
    function automatic front_t decode_front(input logic [FMT_W-1:0] op);
        front_t        f;
        logic [4:0]    g;
        logic [EC-1:0] cont;
        f       = {FRONT_W{1'b0}};
        g       = op[FMT_W-2 -: 5];
        cont    = op[FMT_W-7 -: EC];
        f.sign  = op[FMT_W-1];
        f.trail = op[TW-1:0];
        if (g[4:3] != 2'b11) begin
            f.exp = {g[4:3], cont};
            f.msd = {1'b0, g[2:0]};
        end else if (g[2:1] != 2'b11) begin
            f.exp = {g[2:1], cont};
            f.msd = {3'b100, g[0]};
        end else begin
            f.exp = {EW{1'b0}};
            f.msd = 4'd0;
            if (g[0]) begin
                f.nan  = 1'b1;
                f.snan = op[FMT_W-7];
            end else begin
                f.inf   = 1'b1;
                f.trail = {TW{1'b0}};
            end
        end
        return f;
    endfunction

    // Non-canonical declets fall through the same table without any flag.
    function automatic logic [11:0] decode_declet(input logic [9:0] b);
        logic [11:0] d;
        d = 12'd0;
        if (!b[3]) begin
            d = {1'b0, b[9:7], 1'b0, b[6:4], 1'b0, b[2:0]};
        end else begin
            case (b[2:1])
                2'b00: d = {1'b0, b[9:7], 1'b0, b[6:4], 3'b100, b[0]};
                2'b01: d = {1'b0, b[9:7], 3'b100, b[4], 1'b0, b[6], b[5], b[0]};
                2'b10: d = {3'b100, b[7], 1'b0, b[6:4], 1'b0, b[9], b[8], b[0]};
                2'b11: begin
                    case (b[6:5])
                        2'b00:   d = {3'b100, b[7], 3'b100, b[4], 1'b0, b[9], b[8], b[0]};
                        2'b01:   d = {3'b100, b[7], 1'b0, b[9], b[8], b[4], 3'b100, b[0]};
                        2'b10:   d = {1'b0, b[9:7], 3'b100, b[4], 3'b100, b[0]};
                        2'b11:   d = {3'b100, b[7], 3'b100, b[4], 3'b100, b[0]};
                        default: d = 12'd0;
                    endcase
                end
                default: d = 12'd0;
            endcase
        end
        return d;
    endfunction

    function automatic logic [MW-1:0] decode_coeff(input logic [3:0] msd, input logic [TW-1:0] trail);
        logic [MW-1:0] m;
        m = {MW{1'b0}};
        m[MW-1 -: 4] = msd;
        for (int k = 0; k < NDEC; k++) begin
            m[12*k +: 12] = decode_declet(trail[10*k +: 10]);
        end
        return m;
    endfunction

    logic             p1_valid_r;
    logic             p2_valid_r;
    front_t           p1_a_r;
    front_t           p1_b_r;
    logic [TAG_W-1:0] p1_tag_r;

    logic             adv1_s;
    logic             adv2_s;
    front_t           front_a_s;
    front_t           front_b_s;
    logic [MW-1:0]    coeff_a_s;
    logic [MW-1:0]    coeff_b_s;
    logic             zero_a_s;
    logic             zero_b_s;

    // Stage advance: a stage moves when it is empty or the stage after it moves.
    always_comb begin
        adv2_s = ~p2_valid_r | out_ready;
        adv1_s = ~p1_valid_r | adv2_s;
    end

    assign in_ready  = adv1_s;
    assign out_valid = p2_valid_r;

    // Combination-field decode of the incoming operands.
    always_comb begin
        front_a_s = decode_front(in_op1);
        front_b_s = decode_front(in_op2);
    end

    // Declet decode and zero classification of the stage-1 contents.
    always_comb begin
        coeff_a_s = decode_coeff(p1_a_r.msd, p1_a_r.trail);
        coeff_b_s = decode_coeff(p1_b_r.msd, p1_b_r.trail);
        zero_a_s  = ~p1_a_r.inf & ~p1_a_r.nan & (coeff_a_s == {MW{1'b0}});
        zero_b_s  = ~p1_b_r.inf & ~p1_b_r.nan & (coeff_b_s == {MW{1'b0}});
    end

    // Stage 1 register: raw trailing fields plus decoded combination field.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid_r <= 1'b0;
            p1_a_r     <= {FRONT_W{1'b0}};
            p1_b_r     <= {FRONT_W{1'b0}};
            p1_tag_r   <= {TAG_W{1'b0}};
        end else begin
            if (adv1_s) begin
                p1_valid_r <= in_valid;
            end
            if (adv1_s && in_valid) begin
                p1_a_r   <= front_a_s;
                p1_b_r   <= front_b_s;
                p1_tag_r <= in_tag;
            end
        end
    end

    // Stage 2 register: drives the outputs, which hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            p2_valid_r <= 1'b0;
            out_tag    <= {TAG_W{1'b0}};
            s1         <= 1'b0;
            e1         <= {EW{1'b0}};
            m1         <= {MW{1'b0}};
            inf1       <= 1'b0;
            nan1       <= 1'b0;
            snan1      <= 1'b0;
            zero1      <= 1'b0;
            s2         <= 1'b0;
            e2         <= {EW{1'b0}};
            m2         <= {MW{1'b0}};
            inf2       <= 1'b0;
            nan2       <= 1'b0;
            snan2      <= 1'b0;
            zero2      <= 1'b0;
        end else begin
            if (adv2_s) begin
                p2_valid_r <= p1_valid_r;
            end
            if (adv2_s && p1_valid_r) begin
                out_tag <= p1_tag_r;
                s1      <= p1_a_r.sign;
                e1      <= p1_a_r.exp;
                m1      <= coeff_a_s;
                inf1    <= p1_a_r.inf;
                nan1    <= p1_a_r.nan;
                snan1   <= p1_a_r.snan;
                zero1   <= zero_a_s;
                s2      <= p1_b_r.sign;
                e2      <= p1_b_r.exp;
                m2      <= coeff_b_s;
                inf2    <= p1_b_r.inf;
                nan2    <= p1_b_r.nan;
                snan2   <= p1_b_r.snan;
                zero2   <= zero_b_s;
            end
        end
    end

endmodule

// File: tb/tb_dpd_operand_unpack.sv
// Bench for dpd_operand_unpack: one decimal32 and one decimal64 instance,
// checked against a reference built from an inverted DPD encoder table.
module tb_dpd_operand_unpack;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_op1, a_op2;
    logic [3:0]  a_in_tag, a_out_tag;
    logic        a_s1, a_s2, a_inf1, a_nan1, a_snan1, a_zero1, a_inf2, a_nan2, a_snan2, a_zero2;
    logic [7:0]  a_e1, a_e2;
    logic [27:0] a_m1, a_m2;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_op1, b_op2;
    logic [3:0]  b_in_tag, b_out_tag;
    logic        b_s1, b_s2, b_inf1, b_nan1, b_snan1, b_zero1, b_inf2, b_nan2, b_snan2, b_zero2;
    logic [9:0]  b_e1, b_e2;
    logic [63:0] b_m1, b_m2;

    dpd_operand_unpack #(.FMT_W(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_op1(a_op1), .in_op2(a_op2), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_tag(a_out_tag),
        .s1(a_s1), .s2(a_s2), .e1(a_e1), .e2(a_e2), .m1(a_m1), .m2(a_m2),
        .inf1(a_inf1), .nan1(a_nan1), .snan1(a_snan1), .zero1(a_zero1),
        .inf2(a_inf2), .nan2(a_nan2), .snan2(a_snan2), .zero2(a_zero2)
    );

    dpd_operand_unpack #(.FMT_W(64), .TAG_W(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_op1(b_op1), .in_op2(b_op2), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_tag(b_out_tag),
        .s1(b_s1), .s2(b_s2), .e1(b_e1), .e2(b_e2), .m1(b_m1), .m2(b_m2),
        .inf1(b_inf1), .nan1(b_nan1), .snan1(b_snan1), .zero1(b_zero1),
        .inf2(b_inf2), .nan2(b_nan2), .snan2(b_snan2), .zero2(b_zero2)
    );

    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [63:0] m;
        logic        inf;
        logic        nan;
        logic        snan;
        logic        zero;
    } opr_t;

    typedef struct packed {
        logic [3:0] tag;
        opr_t       o1;
        opr_t       o2;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   dec_tab [0:1023];
    res_t q32 [$];
    res_t q64 [$];

    // Forward DPD encoding of three decimal digits.
    function automatic logic [9:0] encode_dpd(input int h, input int t, input int u);
        logic [3:0] hh, tt, uu;
        logic [9:0] b;
        hh = 4'(h); tt = 4'(t); uu = 4'(u);
        case ({hh[3], tt[3], uu[3]})
            3'b000:  b = {hh[2:0], tt[2:0], 1'b0, uu[2:0]};
            3'b001:  b = {hh[2:0], tt[2:0], 3'b100, uu[0]};
            3'b010:  b = {hh[2:0], uu[2:1], tt[0], 3'b101, uu[0]};
            3'b100:  b = {uu[2:1], hh[0], tt[2:0], 3'b110, uu[0]};
            3'b110:  b = {uu[2:1], hh[0], 2'b00, tt[0], 3'b111, uu[0]};
            3'b101:  b = {tt[2:1], hh[0], 2'b01, tt[0], 3'b111, uu[0]};
            3'b011:  b = {hh[2:0], 2'b10, tt[0], 3'b111, uu[0]};
            default: b = {2'b00, hh[0], 2'b11, tt[0], 3'b111, uu[0]};
        endcase
        return b;
    endfunction

    task automatic build_table();
        for (int i = 0; i < 1024; i++) dec_tab[i] = -1;
        for (int v = 0; v < 1000; v++) dec_tab[encode_dpd(v / 100, (v / 10) % 10, v % 10)] = v;
    endtask

    function automatic opr_t ref_op(input int fmt, input logic [63:0] op);
        opr_t       r;
        int         ec, nd, ndec, g, cont, msd, v;
        logic [9:0] b;
        ec   = (fmt == 32) ? 6 : 8;
        nd   = (fmt == 32) ? 7 : 16;
        ndec = (nd - 1) / 3;
        r    = '0;
        r.s  = op[fmt-1];
        g    = int'((op >> (fmt - 6)) & 64'd31);
        cont = int'((op >> (fmt - 6 - ec)) & ((64'd1 << ec) - 64'd1));
        if (g >= 30) begin
            msd = 0;
            if (g == 30) r.inf = 1'b1;
            else begin
                r.nan  = 1'b1;
                r.snan = op[fmt-7];
            end
        end else if (g >= 24) begin
            r.e = 10'(((g >> 1) & 3) * (1 << ec) + cont);
            msd = 8 + (g & 1);
        end else begin
            r.e = 10'((g >> 3) * (1 << ec) + cont);
            msd = g & 7;
        end
        if (!r.inf) begin
            r.m = 64'(msd) << (4 * (nd - 1));
            for (int k = 0; k < ndec; k++) begin
                b = op[10*k +: 10];
                if (b[3:1] == 3'b111 && b[6:5] == 2'b11) b[9:8] = 2'b00;
                v = dec_tab[b];
                if (v < 0) v = 0;
                r.m = r.m | (64'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10)) << (12 * k));
            end
        end
        r.zero = !r.inf && !r.nan && (r.m == 64'd0);
        return r;
    endfunction

    function automatic res_t ref_pair(input int fmt, input logic [63:0] x1, input logic [63:0] x2, input logic [3:0] t);
        res_t r;
        r.tag = t;
        r.o1  = ref_op(fmt, x1);
        r.o2  = ref_op(fmt, x2);
        return r;
    endfunction

    function automatic opr_t mk(input int s, input int e, input logic [63:0] m, input int inf, input int nan, input int snan, input int zero);
        opr_t r;
        r.s = 1'(s); r.e = 10'(e); r.m = m;
        r.inf = 1'(inf); r.nan = 1'(nan); r.snan = 1'(snan); r.zero = 1'(zero);
        return r;
    endfunction

    function automatic res_t observe(input int fmt);
        res_t r;
        if (fmt == 32) begin
            r.tag = a_out_tag;
            r.o1  = {a_s1, 2'b00, a_e1, 36'd0, a_m1, a_inf1, a_nan1, a_snan1, a_zero1};
            r.o2  = {a_s2, 2'b00, a_e2, 36'd0, a_m2, a_inf2, a_nan2, a_snan2, a_zero2};
        end else begin
            r.tag = b_out_tag;
            r.o1  = {b_s1, b_e1, b_m1, b_inf1, b_nan1, b_snan1, b_zero1};
            r.o2  = {b_s2, b_e2, b_m2, b_inf2, b_nan2, b_snan2, b_zero2};
        end
        return r;
    endfunction

    task automatic drive(input int fmt, input logic v, input logic [63:0] x1, input logic [63:0] x2, input logic [3:0] t, input logic rdy);
        if (fmt == 32) begin
            a_in_valid = v; a_op1 = x1[31:0]; a_op2 = x2[31:0]; a_in_tag = t; a_out_ready = rdy;
        end else begin
            b_in_valid = v; b_op1 = x1; b_op2 = x2; b_in_tag = t; b_out_ready = rdy;
        end
    endtask

    // One clock: observe at the falling edge, record transfers in the scoreboard.
    task automatic tick(input int fmt, output bit acc, output bit popped, output bit rdy, output bit ov,
                        output res_t act, output res_t expv);
        @(negedge clk);
        expv = 'x;
        act  = observe(fmt);
        if (fmt == 32) begin
            rdy = a_in_ready; ov = a_out_valid;
            acc = a_in_valid && a_in_ready;
            popped = a_out_valid && a_out_ready;
            if (acc) q32.push_back(ref_pair(32, {32'd0, a_op1}, {32'd0, a_op2}, a_in_tag));
            if (popped && q32.size() > 0) expv = q32.pop_front();
        end else begin
            rdy = b_in_ready; ov = b_out_valid;
            acc = b_in_valid && b_in_ready;
            popped = b_out_valid && b_out_ready;
            if (acc) q64.push_back(ref_pair(64, b_op1, b_op2, b_in_tag));
            if (popped && q64.size() > 0) expv = q64.pop_front();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov32: got %b expected 0", a_out_valid); end
        checks++; if (observe(32) !== '0) begin errors++; $display("FAIL reset_out32: got %h expected 0", observe(32)); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov64: got %b expected 0", b_out_valid); end
        checks++; if (observe(64) !== '0) begin errors++; $display("FAIL reset_out64: got %h expected 0", observe(64)); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready32: got %b expected 1", a_in_ready); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready64: got %b expected 1", b_in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed(input int fmt, input logic [63:0] op, input opr_t exp1, input logic [3:0] t);
        bit   acc, popped, rdy, ov;
        res_t act, expv;
        opr_t zexp;
        zexp = mk(0, 0, 64'd0, 0, 0, 0, 1);
        drive(fmt, 1'b1, op, 64'd0, t, 1'b1);
        tick(fmt, acc, popped, rdy, ov, act, expv);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL dir_accept %h: got %b expected 1", op, acc); end
        drive(fmt, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1);
        tick(fmt, acc, popped, rdy, ov, act, expv);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL dir_early %h: got out_valid %b expected 0", op, ov); end
        tick(fmt, acc, popped, rdy, ov, act, expv);
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL dir_latency %h: got out_valid %b expected 1", op, ov); end
        checks++; if (act.tag !== t) begin errors++; $display("FAIL dir_tag %h: got %h expected %h", op, act.tag, t); end
        checks++; if (act.o1 !== exp1) begin errors++; $display("FAIL dir_op1 %h: got %h expected %h", op, act.o1, exp1); end
        checks++; if (act.o2 !== zexp) begin errors++; $display("FAIL dir_op2 %h: got %h expected %h", op, act.o2, zexp); end
    endtask

    task automatic test_directed32();
        q32.delete();
        test_directed(32, 64'h22500001, mk(0, 101, 64'h1, 0, 0, 0, 0), 4'd1);
        test_directed(32, 64'h22500000, mk(0, 101, 64'h0, 0, 0, 0, 1), 4'd2);
        test_directed(32, 64'h000000FF, mk(0, 0, 64'h999, 0, 0, 0, 0), 4'd3);
        test_directed(32, 64'h6C000000, mk(0, 64, 64'h9000000, 0, 0, 0, 0), 4'd4);
        test_directed(32, 64'h78000000, mk(0, 0, 64'h0, 1, 0, 0, 0), 4'd5);
        test_directed(32, 64'h7C000000, mk(0, 0, 64'h0, 0, 1, 0, 0), 4'd6);
        test_directed(32, 64'h7E000000, mk(0, 0, 64'h0, 0, 1, 1, 0), 4'd7);
        test_directed(32, 64'h7C0000FF, mk(0, 0, 64'h999, 0, 1, 0, 0), 4'd8);
        test_directed(32, 64'hF80000FF, mk(1, 0, 64'h0, 1, 0, 0, 0), 4'd9);
    endtask

    task automatic test_back_to_back();
        bit   acc, popped, rdy, ov, stall;
        res_t act, expv, snap;
        int   sent, got;
        q32.delete();
        sent = 0; got = 0; snap = '0;
        for (int c = 0; c < 60 && (sent < 8 || q32.size() > 0); c++) begin
            stall = (c >= 4 && c <= 6);
            drive(32, sent < 8, {$urandom, $urandom}, {$urandom, $urandom}, 4'(sent), !stall);
            tick(32, acc, popped, rdy, ov, act, expv);
            if (acc) sent++;
            if (stall) begin
                checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready c%0d: got %b expected 0", c, rdy); end
                if (c == 4) snap = act;
                else begin
                    checks++;
                    if (act !== snap || ov !== 1'b1) begin
                        errors++; $display("FAIL b2b_stable c%0d: got %h/%b expected %h/1", c, act, ov, snap);
                    end
                end
            end
            if (popped) begin
                got++;
                checks++; if (act !== expv) begin errors++; $display("FAIL b2b_result: got %h expected %h", act, expv); end
            end
        end
        checks++; if (got != 8 || sent != 8) begin errors++; $display("FAIL b2b_count: got %0d/%0d expected 8/8", got, sent); end
    endtask

    task automatic test_reset_midflight();
        bit   acc, popped, rdy, ov;
        res_t act, expv;
        int   sent;
        q32.delete();
        sent = 0;
        drive(32, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 4'hA, 1'b0);
        tick(32, acc, popped, rdy, ov, act, expv);
        if (acc) sent++;
        drive(32, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 4'hB, 1'b0);
        tick(32, acc, popped, rdy, ov, act, expv);
        if (acc) sent++;
        drive(32, 1'b0, 64'd0, 64'd0, 4'd0, 1'b0);
        checks++; if (sent != 2 || a_out_valid !== 1'b1) begin errors++; $display("FAIL rst_fill: got %0d/%b expected 2/1", sent, a_out_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_ov: got %b expected 0", a_out_valid); end
        checks++; if (observe(32) !== '0) begin errors++; $display("FAIL rst_out: got %h expected 0", observe(32)); end
        rst = 1'b0;
        q32.delete();
        q64.delete();
        drive(32, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick(32, acc, popped, rdy, ov, act, expv);
            checks++; if (popped) begin errors++; $display("FAIL rst_stale c%0d: got %h expected none", c, act); end
        end
    endtask

    task automatic test_random(input int fmt, input int n);
        bit   acc, popped, rdy, ov;
        res_t act, expv;
        int   sent, qsz;
        sent = 0;
        if (fmt == 32) q32.delete(); else q64.delete();
        qsz = 0;
        for (int c = 0; c < n * 8 + 100 && (sent < n || qsz > 0); c++) begin
            drive(fmt, (sent < n) && ($urandom_range(3) != 0), {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom), $urandom_range(3) != 0);
            tick(fmt, acc, popped, rdy, ov, act, expv);
            if (acc) sent++;
            if (popped) begin
                checks++; if (act !== expv) begin errors++; $display("FAIL rand%0d_result: got %h expected %h", fmt, act, expv); end
            end
            qsz = (fmt == 32) ? q32.size() : q64.size();
        end
        drive(fmt, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1);
        checks++; if (sent != n || qsz != 0) begin errors++; $display("FAIL rand%0d_drain: got %0d sent %0d pending expected %0d/0", fmt, sent, qsz, n); end
    endtask

    task automatic test_dpd64();
        q64.delete();
        test_directed(64, 64'h2238000000000001, mk(0, 398, 64'h1, 0, 0, 0, 0), 4'd5);
        test_directed(64, 64'h7800000000000000, mk(0, 0, 64'h0, 1, 0, 0, 0), 4'd6);
        test_directed(64, 64'h7E000000000003FF, mk(0, 0, 64'h999, 0, 1, 1, 0), 4'd7);
        test_random(64, 10000);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(32, 1'b0, 64'd0, 64'd0, 4'd0, 1'b0);
        drive(64, 1'b0, 64'd0, 64'd0, 4'd0, 1'b0);
        build_table();
        test_reset();
        test_directed32();
        test_back_to_back();
        test_reset_midflight();
        test_random(32, 2000);
        test_dpd64();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
